// File: rtl/lane_unstriper.sv
// rtl/lane_unstriper.sv - two-lane receive FIFOs re-merged into one in-order byte stream
//
// Purpose: buffers each PHY receive lane in its own FIFO and delivers the bytes in
// strict lane 0, lane 1, lane 0, ... order over a valid/ready handshake.
// Ports:
//   clk_8f, reset                 clock, synchronous active-high reset
//   enable                        1 = merging active, 0 = output stalled
//   valid_in_N / data_in_N        lane N byte push (accepted regardless of enable)
//   ready_out                     consumer accepts data_out
//   valid_out / data_out          merged byte, head of the selected lane FIFO
//   lane_sel                      lane the next output byte is taken from
//   overflow_0 / overflow_1       sticky lane-byte-dropped flags
//   byte_count                    delivered bytes, wraps modulo 2^CNT_W
module lane_unstriper #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk_8f,
    input  logic             reset,
    input  logic             enable,
    input  logic             valid_in_0,
    input  logic [7:0]       data_in_0,
    input  logic             valid_in_1,
    input  logic [7:0]       data_in_1,
    input  logic             ready_out,
    output logic             valid_out,
    output logic [7:0]       data_out,
    output logic             lane_sel,
    output logic             overflow_0,
    output logic             overflow_1,
    output logic [CNT_W-1:0] byte_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {
        LANE0 = 1'b0,
        LANE1 = 1'b1
    } lane_state_t;

    lane_state_t state_q, state_d;

    logic [7:0]    mem    [2][DEPTH];
    logic [AW-1:0] wr_ptr [2];
    logic [AW-1:0] rd_ptr [2];
    logic [CW-1:0] count  [2];
    logic [7:0]    din    [2];

    logic [1:0] vin;
    logic [1:0] empty;
    logic [1:0] full;
    logic [1:0] pop;
    logic [1:0] push;
    logic [1:0] drop;
    logic [1:0] ovf_q;
    logic       pop_fire;

    assign vin    = {valid_in_1, valid_in_0};
    assign din[0] = data_in_0;
    assign din[1] = data_in_1;

    always_comb begin
        empty = 2'b00;
        full  = 2'b00;
        for (int i = 0; i < 2; i++) begin
            empty[i] = (count[i] == '0);
            full[i]  = (count[i] == CW'(DEPTH));
        end
    end

    assign lane_sel  = (state_q == LANE1);
    assign valid_out = enable & ~empty[lane_sel];
    assign data_out  = valid_out ? mem[lane_sel][rd_ptr[lane_sel]] : 8'h00;
    assign pop_fire  = valid_out & ready_out;
    assign pop       = {pop_fire & lane_sel, pop_fire & ~lane_sel};

    // A full FIFO still takes a push when its head leaves on the same edge.
    assign push = vin & (~full | pop);
    assign drop = vin & full & ~pop;

    assign overflow_0 = ovf_q[0];
    assign overflow_1 = ovf_q[1];

    // Lane-select FSM: advances only on a delivered byte, never skips a lane.
    always_ff @(posedge clk_8f) begin
        if (reset) begin
            state_q <= LANE0;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (pop_fire) begin
            state_d = (state_q == LANE0) ? LANE1 : LANE0;
        end
    end

    // Storage is not reset; the pointers and counts alone define what is valid.
    always_ff @(posedge clk_8f) begin
        for (int i = 0; i < 2; i++) begin
            if (!reset && push[i]) begin
                mem[i][wr_ptr[i]] <= din[i];
            end
        end
    end

    always_ff @(posedge clk_8f) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
            ovf_q      <= 2'b00;
            byte_count <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (push[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + AW'(1);
                end
                if (pop[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + AW'(1);
                end
                if (push[i] && !pop[i]) begin
                    count[i] <= count[i] + CW'(1);
                end else if (pop[i] && !push[i]) begin
                    count[i] <= count[i] - CW'(1);
                end
            end
            ovf_q <= ovf_q | drop;
            if (pop_fire) begin
                byte_count <= byte_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_lane_unstriper.sv
// tb/tb_lane_unstriper.sv - scoreboard bench for lane_unstriper with a queue-based model
module tb_lane_unstriper;
    localparam int DEPTH = 4;
    localparam int CNT_W = 4;

    logic             clk_8f;
    logic             reset;
    logic             enable;
    logic             valid_in_0;
    logic [7:0]       data_in_0;
    logic             valid_in_1;
    logic [7:0]       data_in_1;
    logic             ready_out;
    logic             valid_out;
    logic [7:0]       data_out;
    logic             lane_sel;
    logic             overflow_0;
    logic             overflow_1;
    logic [CNT_W-1:0] byte_count;

    lane_unstriper #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk_8f     (clk_8f),
        .reset      (reset),
        .enable     (enable),
        .valid_in_0 (valid_in_0),
        .data_in_0  (data_in_0),
        .valid_in_1 (valid_in_1),
        .data_in_1  (data_in_1),
        .ready_out  (ready_out),
        .valid_out  (valid_out),
        .data_out   (data_out),
        .lane_sel   (lane_sel),
        .overflow_0 (overflow_0),
        .overflow_1 (overflow_1),
        .byte_count (byte_count)
    );

    initial clk_8f = 1'b0;
    always #5 clk_8f = ~clk_8f;

    // Reference model: one queue per lane, the lane pointer, delivered count, flags.
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] exp_q[$];
    bit         m_sel;
    int         m_cnt;
    bit         m_ov0;
    bit         m_ov1;

    // Expectations for the cycle currently presented to the DUT.
    bit         chk_en;
    bit         exp_valid;
    logic [7:0] exp_data;
    bit         exp_sel;
    int         exp_cnt;
    bit         exp_ov0;
    bit         exp_ov1;

    int n_cmp;
    int n_err;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    always @(negedge clk_8f) begin
        if (chk_en) begin
            chk("valid_out", 32'(valid_out), 32'(exp_valid));
            chk("data_out", 32'(data_out), 32'(exp_data));
            chk("lane_sel", 32'(lane_sel), 32'(exp_sel));
            chk("byte_count", 32'(byte_count), 32'(exp_cnt));
            chk("overflow_0", 32'(overflow_0), 32'(exp_ov0));
            chk("overflow_1", 32'(overflow_1), 32'(exp_ov1));
            if (valid_out === 1'b1 && ready_out === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_byte", 32'(data_out), 32'hFFFF_FFFF);
                end else begin
                    chk("sb_stream", 32'(data_out), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    // Presents one cycle of stimulus, records the expectations for it, then lets the
    // model take the edge: delivery first, so a full lane can accept a push on that edge.
    task automatic cycle(input bit en, input bit rdy, input bit v0, input logic [7:0] d0,
                         input bit v1, input logic [7:0] d1);
        bit         mv;
        logic [7:0] head;
        reset      = 1'b0;
        enable     = en;
        ready_out  = rdy;
        valid_in_0 = v0;
        data_in_0  = d0;
        valid_in_1 = v1;
        data_in_1  = d1;
        head = 8'h00;
        mv   = en && ((m_sel == 1'b0) ? (q0.size() > 0) : (q1.size() > 0));
        if (mv) head = (m_sel == 1'b0) ? q0[0] : q1[0];
        exp_valid = mv;
        exp_data  = head;
        exp_sel   = m_sel;
        exp_cnt   = m_cnt;
        exp_ov0   = m_ov0;
        exp_ov1   = m_ov1;
        if (mv && rdy) begin
            exp_q.push_back(head);
            if (m_sel == 1'b0) void'(q0.pop_front());
            else               void'(q1.pop_front());
            m_sel = ~m_sel;
            m_cnt = (m_cnt + 1) % (1 << CNT_W);
        end
        if (v0) begin
            if (q0.size() < DEPTH) q0.push_back(d0);
            else                   m_ov0 = 1'b1;
        end
        if (v1) begin
            if (q1.size() < DEPTH) q1.push_back(d1);
            else                   m_ov1 = 1'b1;
        end
        @(posedge clk_8f);
        #1;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        enable     = 1'b0;
        ready_out  = 1'b0;
        valid_in_0 = 1'b0;
        valid_in_1 = 1'b0;
        data_in_0  = 8'h00;
        data_in_1  = 8'h00;
        exp_valid  = 1'b0;
        exp_data   = 8'h00;
        exp_sel    = m_sel;
        exp_cnt    = m_cnt;
        exp_ov0    = m_ov0;
        exp_ov1    = m_ov1;
        @(posedge clk_8f);
        #1;
        q0.delete();
        q1.delete();
        m_sel = 1'b0;
        m_cnt = 0;
        m_ov0 = 1'b0;
        m_ov1 = 1'b0;
    endtask

    task automatic idle(input int n, input bit en, input bit rdy);
        for (int i = 0; i < n; i++) cycle(en, rdy, 1'b0, 8'h00, 1'b0, 8'h00);
    endtask

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        chk_en = 1'b0;
        m_sel  = 1'b0;
        m_cnt  = 0;
        m_ov0  = 1'b0;
        m_ov1  = 1'b0;
        do_reset();
        do_reset();
        chk_en = 1'b1;

        // Reset state, then three paired pushes merged in lane order.
        idle(1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 1'b1, 1'b1, 8'(8'hA0 + 2 * i), 1'b1, 8'(8'hA1 + 2 * i));
        idle(6, 1'b1, 1'b1);

        // Lane 0 overflow while stalled; the fifth byte is lost.
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b1, 8'(8'h10 + i), 1'b0, 8'h00);
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'(8'hB0 + i));
        idle(4, 1'b1, 1'b1);

        // Lane 1 data waits behind an empty lane 0.
        do_reset();
        cycle(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h55);
        idle(3, 1'b1, 1'b1);
        cycle(1'b1, 1'b1, 1'b1, 8'h44, 1'b0, 8'h00);
        idle(4, 1'b1, 1'b1);

        // enable low freezes delivery; resume without loss.
        cycle(1'b1, 1'b0, 1'b1, 8'h61, 1'b1, 8'h62);
        cycle(1'b1, 1'b0, 1'b1, 8'h63, 1'b1, 8'h64);
        idle(3, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b1, 8'h65, 1'b0, 8'h00);
        idle(8, 1'b1, 1'b1);

        // Both FIFOs full, pop and push on the selected lane in one cycle.
        do_reset();
        for (int i = 0; i < DEPTH; i++)
            cycle(1'b1, 1'b0, 1'b1, 8'(8'h20 + i), 1'b1, 8'(8'h30 + i));
        cycle(1'b1, 1'b1, 1'b1, 8'h77, 1'b0, 8'h00);
        idle(2, 1'b1, 1'b0);
        idle(12, 1'b1, 1'b1);

        // Reset mid-stream discards buffered bytes.
        cycle(1'b1, 1'b0, 1'b1, 8'hC0, 1'b1, 8'hC1);
        cycle(1'b1, 1'b0, 1'b1, 8'hC2, 1'b0, 8'h00);
        do_reset();
        idle(5, 1'b1, 1'b1);

        // Randomized traffic, including count wrap and occasional resets.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                cycle($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0,
                      $urandom_range(0, 2) != 0, 8'($urandom),
                      $urandom_range(0, 2) != 0, 8'($urandom));
            end
        end
        idle(12, 1'b1, 1'b1);
        chk_en = 1'b0;
        chk("sb_leftover", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
